// File: rtl/hd44780_pkg.sv
// Shared definitions for the HD44780 parallel-bus write driver:
// FSM state encoding, common instruction bytes and small helpers.
package hd44780_pkg;

  typedef enum logic [2:0] {
    POWERUP = 3'd0,
    IDLE    = 3'd1,
    SETUP   = 3'd2,
    ENABLE  = 3'd3,
    HOLD    = 3'd4,
    EXEC    = 3'd5
  } state_e;

  localparam logic [7:0] CMD_CLEAR        = 8'h01;
  localparam logic [7:0] CMD_HOME         = 8'h02;
  localparam logic [7:0] CMD_FUNCSET_8B2L = 8'h38;
  localparam logic [7:0] CMD_DISP_ON      = 8'h0C;
  localparam logic [7:0] CMD_ENTRY_INC    = 8'h06;

  // Clear Display (0x01) and Return Home (0x02/0x03, DB0 is don't-care)
  // are the only instructions with the long execution time. 0x00 is not
  // a real instruction and gets the short wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return (!rs) && (d[7:2] == 6'b0) && (d[1:0] != 2'b00);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hd44780_delay_counter.sv
// Loadable down-counter shared by every timed FSM state. A load of N-1
// followed by waiting for the zero flag gives a dwell of exactly N cycles.
// The count saturates at zero so an untimed state (IDLE) can sit forever.
module hd44780_delay_counter #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: a load wins, otherwise decrement until zero.
  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_load_val;
    end else if (count_q != '0) begin
      count_d = count_q - ONE;
    end
  end

  // Count register; reset preloads the power-up dwell.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_zero = (count_q == '0);

endmodule

// File: rtl/hd44780_bus_driver.sv
// HD44780 8-bit parallel bus write driver. Takes one command/data byte per
// valid/ready handshake and emits a single write cycle with address setup,
// enable pulse and hold, then blocks for the instruction execution time.
// The busy flag is never read, so RW is tied low.
module hd44780_bus_driver
  import hd44780_pkg::*;
#(
  parameter int unsigned POWERUP_CYC    = 4000000,
  parameter int unsigned SETUP_CYC      = 4,
  parameter int unsigned E_HIGH_CYC     = 25,
  parameter int unsigned HOLD_CYC       = 2,
  parameter int unsigned EXEC_SHORT_CYC = 3700,
  parameter int unsigned EXEC_LONG_CYC  = 152000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_valid,
  output logic       o_ready,
  input  logic       i_rs,
  input  logic [7:0] i_d,
  output logic       o_lcd_rs,
  output logic       o_lcd_rw,
  output logic       o_lcd_e,
  output logic [7:0] o_lcd_d,
  output logic       o_busy
);

  // One counter serves every timed state, so it is sized for the longest.
  localparam int unsigned MAX_CYC = max_u(max_u(max_u(POWERUP_CYC, SETUP_CYC),
                                                max_u(E_HIGH_CYC, HOLD_CYC)),
                                          max_u(EXEC_SHORT_CYC, EXEC_LONG_CYC));
  localparam int unsigned CNT_W = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] POWERUP_LD    = CNT_W'(POWERUP_CYC - 1);
  localparam logic [CNT_W-1:0] SETUP_LD      = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] E_HIGH_LD     = CNT_W'(E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD       = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_SHORT_LD = CNT_W'(EXEC_SHORT_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LONG_LD  = CNT_W'(EXEC_LONG_CYC - 1);

  state_e           state_q;
  state_e           state_d;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             accept;

  logic             ready_q;
  logic             busy_q;
  logic             e_q;
  logic             rs_q;
  logic [7:0]       d_q;
  logic             long_q;

  hd44780_delay_counter #(
    .WIDTH   (CNT_W),
    .RST_VAL (POWERUP_LD)
  ) u_delay (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (cnt_load),
    .i_load_val (cnt_val),
    .o_zero     (cnt_zero)
  );

  // Next-state logic: each timed state loads the dwell of the state it
  // enters and leaves once the counter has drained to zero.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    accept   = 1'b0;
    case (state_q)
      POWERUP: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (i_valid && ready_q) begin
          accept   = 1'b1;
          state_d  = SETUP;
          cnt_load = 1'b1;
          cnt_val  = SETUP_LD;
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          state_d  = ENABLE;
          cnt_load = 1'b1;
          cnt_val  = E_HIGH_LD;
        end
      end
      ENABLE: begin
        if (cnt_zero) begin
          state_d  = HOLD;
          cnt_load = 1'b1;
          cnt_val  = HOLD_LD;
        end
      end
      HOLD: begin
        if (cnt_zero) begin
          state_d  = EXEC;
          cnt_load = 1'b1;
          cnt_val  = long_q ? EXEC_LONG_LD : EXEC_SHORT_LD;
        end
      end
      EXEC: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d  = POWERUP;
        cnt_load = 1'b1;
        cnt_val  = POWERUP_LD;
      end
    endcase
  end

  // State and registered pin/handshake outputs. Ready and busy follow the
  // next state so ready drops on the accepting edge. E is taken from the
  // current state, so it trails ENABLE by one cycle: the address gets
  // SETUP_CYC+1 cycles of setup and RS/D stay frozen until the next accept,
  // which is far beyond the required hold after E falls.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= POWERUP;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      d_q     <= 8'h00;
      long_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      busy_q  <= (state_d != IDLE);
      e_q     <= (state_q == ENABLE);
      if (accept) begin
        rs_q   <= i_rs;
        d_q    <= i_d;
        long_q <= is_long_cmd(i_rs, i_d);
      end
    end
  end

  assign o_ready  = ready_q;
  assign o_busy   = busy_q;
  assign o_lcd_e  = e_q;
  assign o_lcd_rs = rs_q;
  assign o_lcd_d  = d_q;
  assign o_lcd_rw = 1'b0;

endmodule

// File: tb/tb_hd44780_bus_driver.sv
// Self-checking bench for hd44780_bus_driver with shortened timing.
module tb_hd44780_bus_driver;
  import hd44780_pkg::*;

  localparam int P_PWR  = 20;
  localparam int P_SET  = 2;
  localparam int P_EH   = 5;
  localparam int P_HOLD = 2;
  localparam int P_XS   = 10;
  localparam int P_XL   = 40;
  localparam int PER_S  = 1 + P_SET + P_EH + P_HOLD + P_XS;  // 20
  localparam int PER_L  = 1 + P_SET + P_EH + P_HOLD + P_XL;  // 50

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_valid;
  logic       o_ready;
  logic       i_rs;
  logic [7:0] i_d;
  logic       o_lcd_rs;
  logic       o_lcd_rw;
  logic       o_lcd_e;
  logic [7:0] o_lcd_d;
  logic       o_busy;

  always #5 clk = ~clk;

  hd44780_bus_driver #(
    .POWERUP_CYC    (P_PWR),
    .SETUP_CYC      (P_SET),
    .E_HIGH_CYC     (P_EH),
    .HOLD_CYC       (P_HOLD),
    .EXEC_SHORT_CYC (P_XS),
    .EXEC_LONG_CYC  (P_XL)
  ) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_rs     (i_rs),
    .i_d      (i_d),
    .o_lcd_rs (o_lcd_rs),
    .o_lcd_rw (o_lcd_rw),
    .o_lcd_e  (o_lcd_e),
    .o_lcd_d  (o_lcd_d),
    .o_busy   (o_busy)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic rst_at_edge = 1'b1;

  // Edge counter; after posedge k the value reads k.
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= !rst_n;
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Bus monitor: RW always low, RS/D frozen while E is high and for
  // HOLD cycles after it falls; logs every E pulse.
  logic       prev_e     = 1'b0;
  logic [8:0] prev_bus   = '0;
  int         since_fall = 1000;
  int         rise_cyc   = -1;
  int         fall_cyc   = -1;
  logic [8:0] pulse_q[$];

  always @(negedge clk) begin
    tests++;
    if (o_lcd_rw !== 1'b0) begin
      fails++;
      $display("[TB] FAIL rw_low: got %b, expected 0", o_lcd_rw);
    end
    if (rst_at_edge) begin
      prev_e     = 1'b0;
      since_fall = 1000;
    end else begin
      if (prev_e || since_fall < P_HOLD) begin
        tests++;
        if ({o_lcd_rs, o_lcd_d} !== prev_bus) begin
          fails++;
          $display("[TB] FAIL bus_stable: got 0x%0h, expected 0x%0h at edge %0d",
                   {o_lcd_rs, o_lcd_d}, prev_bus, cyc);
        end
      end
      if (o_lcd_e && !prev_e) begin
        pulse_q.push_back({o_lcd_rs, o_lcd_d});
        rise_cyc = cyc;
      end
      if (!o_lcd_e && prev_e) begin
        fall_cyc   = cyc;
        since_fall = 0;
      end else if (since_fall < 1000) begin
        since_fall++;
      end
      prev_e = o_lcd_e;
    end
    prev_bus = {o_lcd_rs, o_lcd_d};
  end

  typedef struct packed {
    logic       rs;
    logic [7:0] d;
    logic [7:0] period;
    logic       toggle;
  } vec_t;

  vec_t vecs[8];

  // Offer one byte, wait for acceptance, then check the write cycle.
  // Called at negedge+1 with the handshake inputs free to change.
  task automatic send_byte(input int idx, input logic rs, input logic [7:0] d,
                           input int exp_period, input bit toggle);
    int a_edge;
    int guard;
    int n0;
    bit got;
    i_valid = 1'b1;
    i_rs    = rs;
    i_d     = d;
    got     = o_ready;
    guard   = 0;
    while (!got && guard < 200) begin
      @(negedge clk); #1;
      guard++;
      got = o_ready;
    end
    if (!got) begin
      chk($sformatf("v%0d_ready_timeout", idx), 0, 1);
      i_valid = 1'b0;
      return;
    end
    chk($sformatf("v%0d_idle_busy", idx), int'(o_busy), 0);
    a_edge = cyc + 1;
    n0     = pulse_q.size();
    @(posedge clk); #2;
    i_valid = 1'b0;
    i_d     = ~d;
    i_rs    = ~rs;
    @(negedge clk); #1;
    $display("[TB] vec %0d: rs=%0d d=0x%02h accepted at edge %0d", idx, rs, d, a_edge);
    chk($sformatf("v%0d_lcd_rs", idx), int'(o_lcd_rs), int'(rs));
    chk($sformatf("v%0d_lcd_d", idx), int'(o_lcd_d), int'(d));
    chk($sformatf("v%0d_ready_clr", idx), int'(o_ready), 0);
    chk($sformatf("v%0d_busy", idx), int'(o_busy), 1);
    got   = 1'b0;
    guard = 0;
    while (!got && guard < 200) begin
      if (toggle) begin
        i_valid = guard[0];
        i_d     = guard[7:0];
      end
      @(negedge clk); #1;
      guard++;
      got = o_ready;
    end
    i_valid = 1'b0;
    if (!got) begin
      chk($sformatf("v%0d_return_timeout", idx), 0, 1);
      return;
    end
    chk($sformatf("v%0d_period", idx), cyc + 1 - a_edge, exp_period);
    chk($sformatf("v%0d_e_rise", idx), rise_cyc - a_edge, P_SET + 1);
    chk($sformatf("v%0d_e_width", idx), fall_cyc - rise_cyc, P_EH);
    chk($sformatf("v%0d_pulses", idx), pulse_q.size() - n0, 1);
    if (pulse_q.size() - n0 == 1) begin
      chk($sformatf("v%0d_pulse_byte", idx), int'(pulse_q[n0]), int'({rs, d}));
    end
  endtask

  // Four bytes with i_valid held high throughout.
  task automatic stream_test();
    logic [7:0] seq[4];
    int acc[4];
    int idx;
    int guard;
    int n0;
    seq[0] = CMD_FUNCSET_8B2L;
    seq[1] = CMD_DISP_ON;
    seq[2] = CMD_CLEAR;
    seq[3] = CMD_ENTRY_INC;
    n0      = pulse_q.size();
    idx     = 0;
    guard   = 0;
    i_valid = 1'b1;
    i_rs    = 1'b0;
    i_d     = seq[0];
    while (idx < 4 && guard < 400) begin
      if (o_ready) begin
        acc[idx] = cyc + 1;
        $display("[TB] stream: d=0x%02h accepted at edge %0d", seq[idx], acc[idx]);
        idx++;
        @(posedge clk); #2;
        if (idx < 4) i_d = seq[idx];
        else i_valid = 1'b0;
      end
      @(negedge clk); #1;
      guard++;
    end
    i_valid = 1'b0;
    if (idx < 4) begin
      chk("stream_timeout", idx, 4);
      return;
    end
    guard = 0;
    while (!o_ready && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("stream_final_ready", int'(o_ready), 1);
    chk("stream_pulses", pulse_q.size() - n0, 4);
    if (pulse_q.size() - n0 == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("stream_byte%0d", i), int'(pulse_q[n0 + i]), int'({1'b0, seq[i]}));
      end
    end
    chk("stream_per01", acc[1] - acc[0], PER_S);
    chk("stream_per12", acc[2] - acc[1], PER_S);
    chk("stream_per23", acc[3] - acc[2], PER_L);
  endtask

  // Reset asserted while E is high.
  task automatic abort_test();
    int guard;
    int rel;
    int n0;
    i_valid = 1'b1;
    i_rs    = 1'b0;
    i_d     = CMD_DISP_ON;
    guard   = 0;
    while (!o_lcd_e && guard < 200) begin
      @(negedge clk); #1;
      guard++;
      if (!o_ready) i_valid = 1'b0;
    end
    i_valid = 1'b0;
    if (!o_lcd_e) begin
      chk("abort_no_e", 0, 1);
      return;
    end
    rst_n = 1'b0;
    @(negedge clk); #1;
    $display("[TB] abort: reset applied during enable at edge %0d", cyc);
    chk("abort_e_low", int'(o_lcd_e), 0);
    chk("abort_ready", int'(o_ready), 0);
    chk("abort_busy", int'(o_busy), 1);
    chk("abort_d", int'(o_lcd_d), 0);
    chk("abort_rs", int'(o_lcd_rs), 0);
    rst_n = 1'b1;
    rel   = cyc;
    n0    = pulse_q.size();
    guard = 0;
    while (!o_ready && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("abort_powerup_len", cyc - rel, P_PWR);
    repeat (30) begin
      @(negedge clk); #1;
    end
    chk("abort_no_resend", pulse_q.size() - n0, 0);
  endtask

  initial begin
    int rel;
    int guard;
    vecs[0] = '{rs: 1'b0, d: 8'h38, period: 8'(PER_S), toggle: 1'b0};
    vecs[1] = '{rs: 1'b1, d: 8'h35, period: 8'(PER_S), toggle: 1'b1};
    vecs[2] = '{rs: 1'b0, d: 8'h01, period: 8'(PER_L), toggle: 1'b0};
    vecs[3] = '{rs: 1'b0, d: 8'h02, period: 8'(PER_L), toggle: 1'b1};
    vecs[4] = '{rs: 1'b0, d: 8'h03, period: 8'(PER_L), toggle: 1'b0};
    vecs[5] = '{rs: 1'b1, d: 8'h01, period: 8'(PER_S), toggle: 1'b0};
    vecs[6] = '{rs: 1'b0, d: 8'h00, period: 8'(PER_S), toggle: 1'b0};
    vecs[7] = '{rs: 1'b0, d: 8'h0C, period: 8'(PER_S), toggle: 1'b1};

    rst_n   = 1'b0;
    i_valid = 1'b1;
    i_rs    = 1'b0;
    i_d     = CMD_FUNCSET_8B2L;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ready", int'(o_ready), 0);
    chk("rst_busy", int'(o_busy), 1);
    chk("rst_e", int'(o_lcd_e), 0);
    chk("rst_rs", int'(o_lcd_rs), 0);
    chk("rst_d", int'(o_lcd_d), 0);

    rst_n = 1'b1;
    rel   = cyc;
    guard = 0;
    while (!o_ready && guard < 200) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("powerup_len", cyc - rel, P_PWR);

    for (int i = 0; i < 8; i++) begin
      send_byte(i, vecs[i].rs, vecs[i].d, int'(vecs[i].period), vecs[i].toggle);
    end

    stream_test();
    abort_test();
    send_byte(8, 1'b0, CMD_ENTRY_INC, PER_S, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
